// File: rtl/sys_defs.sv
// Shared core definitions: issue width, rollback bus width, the ID/EX packet
// with its NOP value, and the issue sequencer state encoding.
`ifndef SYS_DEFS_SV
`define SYS_DEFS_SV

`ifndef WAYS
`define WAYS 4
`endif

`ifndef ROLLBACK_WIDTH
`define ROLLBACK_WIDTH 2
`endif

package sys_defs;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] inst;
  } ID_EX_PACKET;

  localparam ID_EX_PACKET ID_EX_NOP = '{valid: 1'b0, pc: 32'h0000_0000, inst: 32'h0000_0013};

  typedef enum logic {
    ISSUE_RUN    = 1'b0,
    ISSUE_REPLAY = 1'b1
  } ISSUE_SEQ_STATE;

endpackage

`endif

// File: rtl/issue_sequencer_rollback_compactor.sv
// Combinational split of a bundle under a rollback count: which ways issue,
// the held ways compacted to way 0, and whether any held way is valid.
module rollback_compactor
  import sys_defs::*;
(
  input  ID_EX_PACKET [`WAYS-1:0]  cur_packet,
  input  logic [`ROLLBACK_WIDTH:0] rollback,
  output logic [`WAYS-1:0]         issue_mask,
  output ID_EX_PACKET [`WAYS-1:0]  replay_packet,
  output logic                     held_any,
  output logic [`ROLLBACK_WIDTH:0] rollback_clamped
);

  localparam int W = `WAYS;
  localparam logic [`ROLLBACK_WIDTH:0] WAYS_RB = (`ROLLBACK_WIDTH+1)'(`WAYS);

  logic [`ROLLBACK_WIDTH:0] w_rb;
  logic [`ROLLBACK_WIDTH:0] w_n_issue;

  // Clamp rollback, then derive issue mask, compacted held ways and held_any.
  always_comb begin
    if (rollback > WAYS_RB) begin
      w_rb = WAYS_RB;
    end else begin
      w_rb = rollback;
    end
    w_n_issue = WAYS_RB - w_rb;
    held_any  = 1'b0;
    for (int i = 0; i < W; i++) begin
      issue_mask[i] = (i < int'(w_n_issue));
    end
    for (int k = 0; k < W; k++) begin
      held_any = held_any | (cur_packet[k].valid & ~issue_mask[k]);
    end
    // Held way k lands in slot k - n_issue; slots past the rollback count are NOP.
    for (int j = 0; j < W; j++) begin
      replay_packet[j] = ID_EX_NOP;
      for (int k = 0; k < W; k++) begin
        if ((j < int'(w_rb)) && (k == int'(w_n_issue) + j)) begin
          replay_packet[j] = cur_packet[k];
        end else begin
          replay_packet[j] = replay_packet[j];
        end
      end
    end
    rollback_clamped = w_rb;
  end

endmodule

// File: rtl/issue_sequencer.sv
// Issue sequencer: issues the leading ways of each bundle and replays rolled-back
// ways from a buffer. Optional counters are enabled by ISSUE_SEQ_STATS_EN.
module issue_sequencer
  import sys_defs::*;
(
  input  logic                     clock,
  input  logic                     reset,
  input  ID_EX_PACKET [`WAYS-1:0]  in_packet,
  output logic                     in_ready,
  output ID_EX_PACKET [`WAYS-1:0]  cur_packet,
  input  logic [`ROLLBACK_WIDTH:0] rollback,
  input  logic                     stall,
  input  logic                     flush,
  output ID_EX_PACKET [`WAYS-1:0]  issue_packet,
  output logic                     replay_active
`ifdef ISSUE_SEQ_STATS_EN
  ,
  output logic [31:0]              stat_replay_cycles,
  output logic [31:0]              stat_issued_insts,
  output logic [31:0]              stat_full_stall_cycles
`endif
);

  localparam int W = `WAYS;
  localparam logic [`ROLLBACK_WIDTH:0] RB_ZERO = {(`ROLLBACK_WIDTH+1){1'b0}};
  localparam logic [`ROLLBACK_WIDTH:0] WAYS_RB = (`ROLLBACK_WIDTH+1)'(`WAYS);

  ISSUE_SEQ_STATE           r_state, w_state_next;
  ID_EX_PACKET [W-1:0]      r_replay_buf, w_replay_buf_next;
  ID_EX_PACKET [W-1:0]      r_issue_packet, w_issue_next;
  ID_EX_PACKET [W-1:0]      w_replay_packet;
  logic [W-1:0]             w_issue_mask;
  logic                     w_held_any;
  logic [`ROLLBACK_WIDTH:0] w_rb;

  rollback_compactor u_compactor (
    .cur_packet       (cur_packet),
    .rollback         (rollback),
    .issue_mask       (w_issue_mask),
    .replay_packet    (w_replay_packet),
    .held_any         (w_held_any),
    .rollback_clamped (w_rb)
  );

  // Source selection and fetch handshake.
  always_comb begin
    case (r_state)
      ISSUE_RUN:    cur_packet = in_packet;
      ISSUE_REPLAY: cur_packet = r_replay_buf;
      default:      cur_packet = in_packet;
    endcase
    in_ready = ((r_state == ISSUE_RUN) && !stall && ((w_rb == RB_ZERO) || !w_held_any)) || flush;
  end

  // Next state, next replay buffer and next issue bundle; flush beats stall.
  always_comb begin
    w_state_next      = r_state;
    w_replay_buf_next = r_replay_buf;
    w_issue_next      = r_issue_packet;
    if (flush) begin
      w_state_next      = ISSUE_RUN;
      w_replay_buf_next = {W{ID_EX_NOP}};
      w_issue_next      = {W{ID_EX_NOP}};
    end else if (stall) begin
      w_state_next = r_state;
    end else begin
      for (int i = 0; i < W; i++) begin
        w_issue_next[i] = w_issue_mask[i] ? cur_packet[i] : ID_EX_NOP;
      end
      if (w_held_any) begin
        w_state_next      = ISSUE_REPLAY;
        w_replay_buf_next = w_replay_packet;
      end else begin
        w_state_next      = ISSUE_RUN;
        w_replay_buf_next = {W{ID_EX_NOP}};
      end
    end
  end

  // State, replay buffer and ID/EX registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state        <= ISSUE_RUN;
      r_replay_buf   <= {W{ID_EX_NOP}};
      r_issue_packet <= {W{ID_EX_NOP}};
    end else begin
      r_state        <= w_state_next;
      r_replay_buf   <= w_replay_buf_next;
      r_issue_packet <= w_issue_next;
    end
  end

  assign issue_packet  = r_issue_packet;
  assign replay_active = (r_state == ISSUE_REPLAY);

`ifdef ISSUE_SEQ_STATS_EN
  logic [31:0] r_stat_replay, r_stat_issued, r_stat_full;
  logic [31:0] w_issue_cnt;
  logic [32:0] w_issued_sum;

  // Valid ways leaving this cycle, and the saturating running total.
  always_comb begin
    w_issue_cnt = 32'd0;
    for (int i = 0; i < W; i++) begin
      if (w_issue_mask[i] && cur_packet[i].valid) begin
        w_issue_cnt = w_issue_cnt + 32'd1;
      end else begin
        w_issue_cnt = w_issue_cnt;
      end
    end
    w_issued_sum = {1'b0, r_stat_issued} + {1'b0, w_issue_cnt};
  end

  // Saturating counters; flush does not clear them.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_stat_replay <= 32'd0;
      r_stat_issued <= 32'd0;
      r_stat_full   <= 32'd0;
    end else begin
      if ((r_state == ISSUE_REPLAY) && (r_stat_replay != 32'hFFFF_FFFF)) begin
        r_stat_replay <= r_stat_replay + 32'd1;
      end
      if (!stall && !flush) begin
        r_stat_issued <= w_issued_sum[32] ? 32'hFFFF_FFFF : w_issued_sum[31:0];
        if ((w_rb == WAYS_RB) && (r_stat_full != 32'hFFFF_FFFF)) begin
          r_stat_full <= r_stat_full + 32'd1;
        end
      end
    end
  end

  assign stat_replay_cycles     = r_stat_replay;
  assign stat_issued_insts      = r_stat_issued;
  assign stat_full_stall_cycles = r_stat_full;
`endif

endmodule
